// File: rtl/lzc_pkg.sv
// Shared definitions for the leading/trailing-zero counter and normaliser.
package lzc_pkg;

    // Count direction encodings for the MODE parameter.
    localparam int MODE_LEADING  = 32'sd0;
    localparam int MODE_TRAILING = 32'sd1;

    // Reference configuration of the reciprocal datapath front end.
    localparam int WIDTH_DEF = 32'sd24;
    localparam int GROUP_DEF = 32'sd4;

    // Ceiling log2; the number of bits needed to index 'value' items.
    function automatic int clog2(input int value);
        int res;
        int pow;
        res = 32'sd0;
        pow = 32'sd1;
        while (pow < value) begin
            pow = pow * 32'sd2;
            res = res + 32'sd1;
        end
        return res;
    endfunction

    // Number of first-level groups for a given operand and group width.
    function automatic int calc_ng(input int width, input int group);
        return width / group;
    endfunction

    // Width of the zero count, wide enough to hold 'width' itself.
    function automatic int calc_cw(input int width);
        return clog2(width + 32'sd1);
    endfunction

    // Width of a group-local count; never narrower than one bit.
    function automatic int calc_lw(input int group);
        return (clog2(group) < 32'sd1) ? 32'sd1 : clog2(group);
    endfunction

    localparam int NG = calc_ng(WIDTH_DEF, GROUP_DEF);
    localparam int CW = calc_cw(WIDTH_DEF);

endpackage

// File: rtl/lzc_group.sv
// First-level group detector: all-zero flag and MSB-side local zero count.
module lzc_group
    import lzc_pkg::*;
#(
    parameter int GROUP = 4,
    localparam int LW = calc_lw(GROUP)
) (
    input  logic [GROUP-1:0] grp_data,
    output logic             grp_zero,
    output logic [LW-1:0]    grp_count
);

    // Scan upward so the highest set bit is the last one to win the count.
    always_comb begin
        grp_zero  = 1'b1;
        grp_count = {LW{1'b0}};
        for (int i = 0; i < GROUP; i++) begin
            grp_count = grp_data[i] ? LW'(GROUP - 1 - i) : grp_count;
            grp_zero  = grp_zero & ~grp_data[i];
        end
    end

endmodule

// File: rtl/lzc_norm_pipe.sv
// Two-stage pipelined leading/trailing-zero counter and normaliser.
// Stage 1 registers group detector results; stage 2 encodes, shifts and
// registers every output. Trailing mode reuses the leading-zero path by
// bit-reversing the operand on entry and the normalised value on exit.
module lzc_norm_pipe
    import lzc_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int GROUP = 4,
    parameter int MODE  = 0,
    parameter int TAG_W = 4,
    localparam int CW = calc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_norm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N_GRP = calc_ng(WIDTH, GROUP);
    localparam int LW    = calc_lw(GROUP);

    if ((WIDTH % GROUP) != 0 || WIDTH < 2 * GROUP) begin : g_bad_width
        $error("lzc_norm_pipe: WIDTH must be a multiple of GROUP and at least 2*GROUP");
    end
    if (MODE != MODE_LEADING && MODE != MODE_TRAILING) begin : g_bad_mode
        $error("lzc_norm_pipe: MODE must be 0 or 1");
    end

    logic [WIDTH-1:0] op_s;
    logic [N_GRP-1:0] grp_zero_s;
    logic [LW-1:0]    grp_cnt_s [N_GRP];

    logic             s1_valid_r;
    logic [N_GRP-1:0] s1_zero_r;
    logic [LW-1:0]    s1_cnt_r [N_GRP];
    logic [WIDTH-1:0] s1_data_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic [CW-1:0]    enc_count_s;
    logic             enc_zero_s;
    logic [WIDTH-1:0] shift_s;
    logic [WIDTH-1:0] norm_s;

    logic             adv_s;
    logic             in_ready_s;

    logic             out_valid_r;
    logic [CW-1:0]    out_count_r;
    logic             out_zero_r;
    logic [WIDTH-1:0] out_norm_r;
    logic [TAG_W-1:0] out_tag_r;

    if (MODE == MODE_TRAILING) begin : g_rev
        // Mirror the operand on entry and the normalised value on exit.
        always_comb begin
            op_s   = {WIDTH{1'b0}};
            norm_s = {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                op_s[i]   = in_data[WIDTH-1-i];
                norm_s[i] = shift_s[WIDTH-1-i];
            end
        end
    end else begin : g_fwd
        assign op_s   = in_data;
        assign norm_s = shift_s;
    end

    // Group 0 is the most-significant slice of the (possibly mirrored) operand.
    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
        lzc_group #(.GROUP(GROUP)) u_grp (
            .grp_data  (op_s[WIDTH-1-g*GROUP -: GROUP]),
            .grp_zero  (grp_zero_s[g]),
            .grp_count (grp_cnt_s[g])
        );
    end

    // Stage 2 moves when its result is taken or it holds nothing.
    assign adv_s      = out_ready | ~out_valid_r;
    assign in_ready_s = ~s1_valid_r | adv_s;
    assign in_ready   = in_ready_s;

    // Stage 1 register: detector flags, local counts, operand and tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_zero_r  <= {N_GRP{1'b0}};
            s1_data_r  <= {WIDTH{1'b0}};
            s1_tag_r   <= {TAG_W{1'b0}};
            for (int g = 0; g < N_GRP; g++) begin
                s1_cnt_r[g] <= {LW{1'b0}};
            end
        end else if (in_ready_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_zero_r <= grp_zero_s;
                s1_data_r <= op_s;
                s1_tag_r  <= in_tag;
                for (int g = 0; g < N_GRP; g++) begin
                    s1_cnt_r[g] <= grp_cnt_s[g];
                end
            end
        end
    end

    // Priority-encode the first non-zero group and shift its leading one to the top.
    always_comb begin
        enc_count_s = CW'(WIDTH);
        enc_zero_s  = 1'b1;
        for (int g = N_GRP - 1; g >= 0; g--) begin
            enc_count_s = s1_zero_r[g] ? enc_count_s
                                       : (CW'(g * GROUP) + CW'(s1_cnt_r[g]));
            enc_zero_s  = enc_zero_s & s1_zero_r[g];
        end
        shift_s = enc_zero_s ? {WIDTH{1'b0}} : (s1_data_r << enc_count_s);
    end

    // Stage 2 output register; holds its contents while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_count_r <= {CW{1'b0}};
            out_zero_r  <= 1'b0;
            out_norm_r  <= {WIDTH{1'b0}};
            out_tag_r   <= {TAG_W{1'b0}};
        end else if (adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_count_r <= enc_count_s;
                out_zero_r  <= enc_zero_s;
                out_norm_r  <= norm_s;
                out_tag_r   <= s1_tag_r;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_count = out_count_r;
    assign out_zero  = out_zero_r;
    assign out_norm  = out_norm_r;
    assign out_tag   = out_tag_r;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Directed and random self-checking bench for lzc_norm_pipe.
// Instance a: WIDTH=24 GROUP=4 leading; b: WIDTH=24 GROUP=4 trailing;
// c: WIDTH=32 GROUP=8 leading, checked against a behavioural model.
module tb_lzc_norm_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_zero;
    logic [23:0] a_in_data, a_out_norm;
    logic [3:0]  a_in_tag, a_out_tag;
    logic [4:0]  a_out_count;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_zero;
    logic [23:0] b_in_data, b_out_norm;
    logic [3:0]  b_in_tag, b_out_tag;
    logic [4:0]  b_out_count;

    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_zero;
    logic [31:0] c_in_data, c_out_norm;
    logic [3:0]  c_in_tag, c_out_tag;
    logic [5:0]  c_out_count;

    int n_vec = 0;
    int n_err = 0;

    lzc_norm_pipe #(.WIDTH(24), .GROUP(4), .MODE(0), .TAG_W(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
        .out_zero(a_out_zero), .out_norm(a_out_norm), .out_tag(a_out_tag)
    );

    lzc_norm_pipe #(.WIDTH(24), .GROUP(4), .MODE(1), .TAG_W(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
        .out_zero(b_out_zero), .out_norm(b_out_norm), .out_tag(b_out_tag)
    );

    lzc_norm_pipe #(.WIDTH(32), .GROUP(8), .MODE(0), .TAG_W(4)) u_dut_c (
        .clk(clk), .reset(reset),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_count(c_out_count),
        .out_zero(c_out_zero), .out_norm(c_out_norm), .out_tag(c_out_tag)
    );

    // Directed boundary vectors with hand-computed results.
    localparam logic [23:0] VIN    [5] = '{24'h800000, 24'h000001, 24'h000000, 24'h00F3A0, 24'h000040};
    localparam int          A_CNT  [5] = '{0, 23, 24, 8, 17};
    localparam logic [23:0] A_NORM [5] = '{24'h800000, 24'h800000, 24'h000000, 24'hF3A000, 24'h800000};
    localparam int          B_CNT  [5] = '{23, 0, 24, 5, 6};
    localparam logic [23:0] B_NORM [5] = '{24'h000001, 24'h000001, 24'h000000, 24'h00079D, 24'h000001};
    localparam logic        V_ZERO [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Back-pressure stream, tags 1..6.
    localparam logic [23:0] BP_DATA [6] = '{24'h800000, 24'h400000, 24'h0F0000, 24'h000100, 24'h000003, 24'h000000};
    localparam int          BP_CNT  [6] = '{0, 1, 4, 15, 22, 24};
    localparam logic [23:0] BP_NORM [6] = '{24'h800000, 24'h800000, 24'hF00000, 24'h800000, 24'hC00000, 24'h000000};

    function automatic int ref_lz32(input logic [31:0] x);
        int r;
        r = 32;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) r = 31 - i;
        end
        return r;
    endfunction

    function automatic logic [31:0] gen_op();
        if ($urandom_range(0, 9) == 0) return 32'h0;
        return $urandom >> $urandom_range(0, 31);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
        n_vec++; if (a_out_count !== 5'd0) begin n_err++; $display("FAIL reset_out_count: got %0d want 0", a_out_count); end
        n_vec++; if (a_out_zero !== 1'b0) begin n_err++; $display("FAIL reset_out_zero: got %b want 0", a_out_zero); end
        n_vec++; if (a_out_norm !== 24'h0) begin n_err++; $display("FAIL reset_out_norm: got %h want 0", a_out_norm); end
        n_vec++; if (a_out_tag !== 4'h0) begin n_err++; $display("FAIL reset_out_tag: got %h want 0", a_out_tag); end
        n_vec++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_c_valid: got %b want 0", c_out_valid); end
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
    endtask

    task automatic test_boundary();
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                n_vec++; if (a_out_valid !== 1'b1 || a_out_tag !== 4'(i - 1)) begin
                    n_err++; $display("FAIL bnd_a_valid[%0d]: got v=%b t=%0d want v=1 t=%0d", i - 2, a_out_valid, a_out_tag, i - 1); end
                n_vec++; if (a_out_count !== 5'(A_CNT[i-2]) || a_out_zero !== V_ZERO[i-2]) begin
                    n_err++; $display("FAIL bnd_a_count[%0d]: got %0d/%b want %0d/%b", i - 2, a_out_count, a_out_zero, A_CNT[i-2], V_ZERO[i-2]); end
                n_vec++; if (a_out_norm !== A_NORM[i-2]) begin
                    n_err++; $display("FAIL bnd_a_norm[%0d]: got %h want %h", i - 2, a_out_norm, A_NORM[i-2]); end
                n_vec++; if (b_out_valid !== 1'b1 || b_out_count !== 5'(B_CNT[i-2]) || b_out_zero !== V_ZERO[i-2]) begin
                    n_err++; $display("FAIL bnd_b_count[%0d]: got v=%b %0d/%b want %0d/%b", i - 2, b_out_valid, b_out_count, b_out_zero, B_CNT[i-2], V_ZERO[i-2]); end
                n_vec++; if (b_out_norm !== B_NORM[i-2]) begin
                    n_err++; $display("FAIL bnd_b_norm[%0d]: got %h want %h", i - 2, b_out_norm, B_NORM[i-2]); end
            end
            if (i < 5) begin
                a_in_valid = 1'b1; a_in_data = VIN[i]; a_in_tag = 4'(i + 1);
                b_in_valid = 1'b1; b_in_data = VIN[i]; b_in_tag = 4'(i + 1);
            end else begin
                a_in_valid = 1'b0;
                b_in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_pressure();
        int sent = 0;
        int recv = 0;
        logic saw_stall = 1'b0;
        logic prev_hold = 1'b0;
        logic [34:0] held = 35'h0;
        for (int c = 0; c < 40 && recv < 6; c++) begin
            @(negedge clk);
            a_out_ready = !(c >= 3 && c <= 6);
            if (sent < 6) begin
                a_in_valid = 1'b1; a_in_data = BP_DATA[sent]; a_in_tag = 4'(sent + 1);
            end else begin
                a_in_valid = 1'b0;
            end
            #1;
            if (prev_hold) begin
                n_vec++; if ({a_out_valid, a_out_count, a_out_zero, a_out_norm, a_out_tag} !== held) begin
                    n_err++; $display("FAIL bp_hold[c%0d]: got %h want %h", c, {a_out_valid, a_out_count, a_out_zero, a_out_norm, a_out_tag}, held); end
            end
            if (a_out_valid) begin
                n_vec++;
                if (recv >= 6) begin
                    n_err++; $display("FAIL bp_extra: got tag %0d want none", a_out_tag);
                end else if (a_out_tag !== 4'(recv + 1) || a_out_count !== 5'(BP_CNT[recv]) ||
                             a_out_norm !== BP_NORM[recv] || a_out_zero !== (recv == 5)) begin
                    n_err++; $display("FAIL bp_result[%0d]: got t=%0d c=%0d n=%h z=%b want t=%0d c=%0d n=%h",
                                      recv, a_out_tag, a_out_count, a_out_norm, a_out_zero, recv + 1, BP_CNT[recv], BP_NORM[recv]);
                end
                if (a_out_ready) recv++;
            end
            if (c == 7) begin
                n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_rise: got %b want 1", a_in_ready); end
            end
            if (!a_in_ready) saw_stall = 1'b1;
            if (a_in_valid && a_in_ready) sent++;
            prev_hold = a_out_valid && !a_out_ready;
            held = {a_out_valid, a_out_count, a_out_zero, a_out_norm, a_out_tag};
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        n_vec++; if (recv != 6 || sent != 6) begin n_err++; $display("FAIL bp_count: got sent=%0d recv=%0d want 6/6", sent, recv); end
        n_vec++; if (saw_stall !== 1'b1) begin n_err++; $display("FAIL bp_stall: got in_ready never low, want a stall"); end
    endtask

    task automatic test_reset_flush();
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 24'h123456; a_in_tag = 4'd7;
        @(negedge clk);
        a_in_data = 24'h00ABCD; a_in_tag = 4'd8;
        @(negedge clk);
        a_in_valid = 1'b0;
        n_vec++; if (a_out_valid !== 1'b1 || a_out_tag !== 4'd7) begin
            n_err++; $display("FAIL flush_inflight: got v=%b t=%0d want v=1 t=7", a_out_valid, a_out_tag); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        a_out_ready = 1'b1;
        #1;
        n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", a_out_valid); end
        n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", a_in_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++; if (a_out_valid !== 1'b0) begin
                n_err++; $display("FAIL flush_ghost[%0d]: got tag %0d valid, want no result", i, a_out_tag); end
        end
    endtask

    task automatic test_random();
        int          q_cnt  [$];
        logic [31:0] q_norm [$];
        logic [3:0]  q_tag  [$];
        int          sent = 0;
        int          recv = 0;
        logic        need_new = 1'b1;
        int          ec;
        logic [31:0] en;
        logic [3:0]  et;
        for (int cyc = 0; cyc < 40000 && recv < 10000; cyc++) begin
            @(negedge clk);
            if (sent < 10000) begin
                if (need_new) begin
                    c_in_data = gen_op();
                    c_in_tag  = 4'(sent);
                    need_new  = 1'b0;
                end
                c_in_valid = 1'b1;
            end else begin
                c_in_valid = 1'b0;
            end
            c_out_ready = ($urandom_range(0, 9) != 0);
            #1;
            if (c_out_valid && c_out_ready) begin
                n_vec++;
                if (q_cnt.size() == 0) begin
                    n_err++; $display("FAIL rnd_extra: got tag %0d want none", c_out_tag);
                end else begin
                    ec = q_cnt.pop_front();
                    en = q_norm.pop_front();
                    et = q_tag.pop_front();
                    if (c_out_count !== 6'(ec) || c_out_norm !== en || c_out_zero !== (ec == 32) || c_out_tag !== et) begin
                        n_err++; $display("FAIL rnd[%0d]: got c=%0d n=%h z=%b t=%0d want c=%0d n=%h t=%0d",
                                          recv, c_out_count, c_out_norm, c_out_zero, c_out_tag, ec, en, et);
                    end
                end
                recv++;
            end
            if (c_in_valid && c_in_ready) begin
                ec = ref_lz32(c_in_data);
                q_cnt.push_back(ec);
                q_norm.push_back((ec == 32) ? 32'h0 : (c_in_data << ec));
                q_tag.push_back(c_in_tag);
                sent++;
                need_new = 1'b1;
            end
        end
        c_in_valid = 1'b0;
        n_vec++; if (recv != 10000) begin n_err++; $display("FAIL rnd_timeout: got %0d results want 10000", recv); end
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 1'b0; a_in_data = 24'h0; a_in_tag = 4'h0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 24'h0; b_in_tag = 4'h0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = 32'h0; c_in_tag = 4'h0; c_out_ready = 1'b1;
        test_reset();
        test_boundary();
        test_back_pressure();
        test_reset_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
